// File: rtl/tsn_dma_wr_arbiter_if.sv
// Requester-side and downstream-FIFO-side signals of the four-way DMA write arbiter.
// The slave modport is the arbiter; the master modport is requesters plus FIFO.
interface tsn_dma_wr_arbiter_if #(
    parameter int unsigned DATA_W = 128
);
    logic              dma_req_a;
    logic              dma_req_b;
    logic              dma_req_c;
    logic              dma_req_d;
    logic              dma_resp_a;
    logic              dma_resp_b;
    logic              dma_resp_c;
    logic              dma_resp_d;
    logic              dma_write_valid_a;
    logic              dma_write_valid_b;
    logic              dma_write_valid_c;
    logic              dma_write_valid_d;
    logic [DATA_W-1:0] dma_write_data_a;
    logic [DATA_W-1:0] dma_write_data_b;
    logic [DATA_W-1:0] dma_write_data_c;
    logic [DATA_W-1:0] dma_write_data_d;
    logic              dma_write_ready_a;
    logic              dma_write_ready_b;
    logic              dma_write_ready_c;
    logic              dma_write_ready_d;
    logic              ff_wr_en;
    logic [DATA_W-1:0] ff_wr_data;
    logic              ff_full;

    modport slave (
        input  dma_req_a, dma_req_b, dma_req_c, dma_req_d,
        input  dma_write_valid_a, dma_write_valid_b, dma_write_valid_c, dma_write_valid_d,
        input  dma_write_data_a, dma_write_data_b, dma_write_data_c, dma_write_data_d,
        input  ff_full,
        output dma_resp_a, dma_resp_b, dma_resp_c, dma_resp_d,
        output dma_write_ready_a, dma_write_ready_b, dma_write_ready_c, dma_write_ready_d,
        output ff_wr_en, ff_wr_data
    );

    modport master (
        output dma_req_a, dma_req_b, dma_req_c, dma_req_d,
        output dma_write_valid_a, dma_write_valid_b, dma_write_valid_c, dma_write_valid_d,
        output dma_write_data_a, dma_write_data_b, dma_write_data_c, dma_write_data_d,
        output ff_full,
        input  dma_resp_a, dma_resp_b, dma_resp_c, dma_resp_d,
        input  dma_write_ready_a, dma_write_ready_b, dma_write_ready_c, dma_write_ready_d,
        input  ff_wr_en, ff_wr_data
    );
endinterface

// File: rtl/tsn_dma_wr_arbiter.sv
// Round-robin arbiter granting one of four DMA requesters a whole packet
// (header beat carrying the payload length, then that many payload beats) into one FIFO.
module tsn_dma_wr_arbiter #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned LEN_LSB = 56
) (
    input  logic                   fpu_clk,
    input  logic                   reset,
    tsn_dma_wr_arbiter_if.slave    bus,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic                   pkt_done
);
    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned LEN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [ID_W-1:0]    rr_ptr_q,   rr_ptr_d;
    logic [ID_W-1:0]    grant_q,    grant_d;
    logic [LEN_W-1:0]   len_q,      len_d;
    logic [LEN_W-1:0]   cnt_q,      cnt_d;
    logic [N_REQ-1:0]   resp_q,     resp_d;
    logic               busy_q,     busy_d;
    logic               pkt_done_q, pkt_done_d;

    logic [N_REQ-1:0]   req_vec;
    logic [N_REQ-1:0]   valid_vec;
    logic [DATA_W-1:0]  data_arr [N_REQ];
    logic [DATA_W-1:0]  gnt_data;
    logic [LEN_W-1:0]   hdr_len;
    logic [ID_W-1:0]    winner;
    logic               accept;

    assign req_vec   = {bus.dma_req_d, bus.dma_req_c, bus.dma_req_b, bus.dma_req_a};
    assign valid_vec = {bus.dma_write_valid_d, bus.dma_write_valid_c,
                        bus.dma_write_valid_b, bus.dma_write_valid_a};
    assign data_arr[0] = bus.dma_write_data_a;
    assign data_arr[1] = bus.dma_write_data_b;
    assign data_arr[2] = bus.dma_write_data_c;
    assign data_arr[3] = bus.dma_write_data_d;

    assign gnt_data = data_arr[grant_q];
    assign hdr_len  = gnt_data[LEN_LSB +: LEN_W];
    // resp_q is one-hot on the grant only in HDR/DATA, so it gates acceptance directly
    assign accept   = resp_q[grant_q] & valid_vec[grant_q] & ~bus.ff_full;

    // Scan from farthest to nearest so the requester closest to rr_ptr wins
    always_comb begin
        winner = rr_ptr_q;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_vec[rr_ptr_q + ID_W'(i)]) begin
                winner = rr_ptr_q + ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    grant_d = winner;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    len_d   = hdr_len;
                    cnt_d   = '0;
                    state_d = (hdr_len == '0) ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                rr_ptr_d = grant_q + ID_W'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d != ST_IDLE);
        pkt_done_d = (state_d == ST_DONE);
        resp_d     = ((state_d == ST_HDR) || (state_d == ST_DATA))
                   ? (N_REQ'(1) << grant_d) : '0;
    end

    always_ff @(posedge fpu_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            resp_q     <= '0;
            busy_q     <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            busy_q     <= busy_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign pkt_done = pkt_done_q;

    assign bus.dma_resp_a = resp_q[0];
    assign bus.dma_resp_b = resp_q[1];
    assign bus.dma_resp_c = resp_q[2];
    assign bus.dma_resp_d = resp_q[3];

    assign bus.dma_write_ready_a = resp_q[0] & ~bus.ff_full;
    assign bus.dma_write_ready_b = resp_q[1] & ~bus.ff_full;
    assign bus.dma_write_ready_c = resp_q[2] & ~bus.ff_full;
    assign bus.dma_write_ready_d = resp_q[3] & ~bus.ff_full;

    assign bus.ff_wr_en   = accept;
    assign bus.ff_wr_data = gnt_data;
endmodule

// File: tb/tb_tsn_dma_wr_arbiter.sv
// Self-checking bench: directed packet scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level packet model.
module tb_tsn_dma_wr_arbiter;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned LEN_LSB = 56;

    logic              fpu_clk = 1'b0;
    logic              reset;
    logic [1:0]        grant_id;
    logic              busy;
    logic              pkt_done;

    logic [3:0]        req;
    logic [3:0]        valid;
    logic              full;
    logic [DATA_W-1:0] data [4];
    logic [3:0]        resp;
    logic [3:0]        rdy;

    tsn_dma_wr_arbiter_if #(.DATA_W(DATA_W)) bus ();

    tsn_dma_wr_arbiter #(.DATA_W(DATA_W), .LEN_LSB(LEN_LSB)) dut (
        .fpu_clk  (fpu_clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .pkt_done (pkt_done)
    );

    always #5 fpu_clk = ~fpu_clk;

    assign bus.dma_req_a = req[0];
    assign bus.dma_req_b = req[1];
    assign bus.dma_req_c = req[2];
    assign bus.dma_req_d = req[3];
    assign bus.dma_write_valid_a = valid[0];
    assign bus.dma_write_valid_b = valid[1];
    assign bus.dma_write_valid_c = valid[2];
    assign bus.dma_write_valid_d = valid[3];
    assign bus.dma_write_data_a = data[0];
    assign bus.dma_write_data_b = data[1];
    assign bus.dma_write_data_c = data[2];
    assign bus.dma_write_data_d = data[3];
    assign bus.ff_full = full;
    assign resp = {bus.dma_resp_d, bus.dma_resp_c, bus.dma_resp_b, bus.dma_resp_a};
    assign rdy  = {bus.dma_write_ready_d, bus.dma_write_ready_c,
                   bus.dma_write_ready_b, bus.dma_write_ready_a};

    int n_checks = 0;
    int n_fail   = 0;

    // Packet-level model: who owns the FIFO, how many beats remain, done pending
    int m_owner = -1;
    bit m_hdr_done = 1'b0;
    int m_left = 0;
    bit m_done = 1'b0;
    int m_grant = 0;
    int m_ptr = 0;

    // Observations for directed scenarios
    int obs_wr, obs_resp_b, obs_done, obs_dead, obs_rdyb, obs_stall_bad, cyc;
    int last_wr_cyc, done_cyc;
    int done_q[$];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] hdr(input int len);
        logic [DATA_W-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        v[LEN_LSB +: 16] = 16'(len);
        v[15:0] = 16'h1234;
        return v;
    endfunction

    task automatic check_model();
        logic [3:0] e_resp;
        logic       e_wen;
        e_resp = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e_wen  = (m_owner >= 0) && valid[m_owner] && !full;
        chk("busy",     DATA_W'(busy),     DATA_W'((m_owner >= 0) || m_done));
        chk("pkt_done", DATA_W'(pkt_done), DATA_W'(m_done));
        chk("grant_id", DATA_W'(grant_id), DATA_W'(m_grant));
        chk("resp",     DATA_W'(resp),     DATA_W'(e_resp));
        chk("ready",    DATA_W'(rdy),      DATA_W'(full ? 4'b0000 : e_resp));
        chk("ff_wr_en", DATA_W'(bus.ff_wr_en), DATA_W'(e_wen));
        if (e_wen) chk("ff_wr_data", bus.ff_wr_data, data[m_owner]);
    endtask

    // Advances the model across the coming rising edge using the inputs now applied
    task automatic model_step();
        if (reset) begin
            m_owner = -1; m_done = 1'b0; m_ptr = 0; m_grant = 0; m_left = 0;
            return;
        end
        if (m_done) begin
            m_done = 1'b0;
            m_ptr  = (m_grant + 1) % 4;
        end else if (m_owner < 0) begin
            for (int d = 0; d < 4; d++) begin
                if (req[(m_ptr + d) % 4]) begin
                    m_owner = (m_ptr + d) % 4;
                    m_grant = m_owner;
                    m_hdr_done = 1'b0;
                    break;
                end
            end
        end else if (valid[m_owner] && !full) begin
            if (!m_hdr_done) begin
                m_hdr_done = 1'b1;
                m_left = int'(data[m_owner][LEN_LSB +: 16]);
            end else begin
                m_left--;
            end
            if (m_left == 0) begin
                m_owner = -1;
                m_done  = 1'b1;
            end
        end
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge
    task automatic tick();
        #1;
        check_model();
        if (bus.ff_wr_en) begin
            obs_wr++;
            last_wr_cyc = cyc;
            if (bus.ff_wr_data == DATA_W'(16'hDEAD)) obs_dead++;
        end
        if (resp[1]) obs_resp_b++;
        if (rdy[1]) obs_rdyb++;
        if (full && (rdy != 4'b0000 || bus.ff_wr_en)) obs_stall_bad++;
        if (pkt_done) begin
            obs_done++;
            done_cyc = cyc;
            done_q.push_back(int'(grant_id));
        end
        cyc++;
        model_step();
        @(negedge fpu_clk);
    endtask

    task automatic clear_obs();
        obs_wr = 0; obs_resp_b = 0; obs_done = 0; obs_dead = 0; obs_rdyb = 0;
        obs_stall_bad = 0; cyc = 0; last_wr_cyc = -10; done_cyc = -20;
        done_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; valid = '0; full = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while (obs_done == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", DATA_W'(obs_done != 0), DATA_W'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [5];
        int stall;
        int n;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) data[i] = '0;
        reset = 1'b1; req = '0; valid = '0; full = 1'b0;
        clear_obs();
        @(negedge fpu_clk);
        do_reset();

        chk("rst_busy",     DATA_W'(busy),        DATA_W'(0));
        chk("rst_pkt_done", DATA_W'(pkt_done),    DATA_W'(0));
        chk("rst_grant",    DATA_W'(grant_id),    DATA_W'(0));
        chk("rst_resp",     DATA_W'(resp),        DATA_W'(0));
        chk("rst_ready",    DATA_W'(rdy),         DATA_W'(0));
        chk("rst_wr_en",    DATA_W'(bus.ff_wr_en), DATA_W'(0));

        // Single requester b, len=3
        clear_obs();
        req = 4'b0010; valid = 4'b0010; data[1] = hdr(3);
        run_until_done(30);
        req = '0; valid = '0;
        chk("b_writes",   DATA_W'(obs_wr),     DATA_W'(4));
        chk("b_resp_cyc", DATA_W'(obs_resp_b), DATA_W'(4));
        chk("b_grant",    DATA_W'(done_q.size() > 0 ? done_q[0] : -1), DATA_W'(1));
        chk("b_done_lat", DATA_W'(done_cyc - last_wr_cyc), DATA_W'(1));
        tick(); tick();

        // All four requesting, len=1 each: a,b,c,d,a
        do_reset();
        clear_obs();
        req = 4'b1111; valid = 4'b1111;
        for (int i = 0; i < 4; i++) data[i] = hdr(1);
        n = 0;
        while (obs_done < 5 && n < 100) begin tick(); n++; end
        req = '0; valid = '0;
        chk("rr_npkts", DATA_W'(done_q.size()), DATA_W'(5));
        for (int i = 0; i < 5 && i < done_q.size(); i++)
            chk("rr_order", DATA_W'(done_q[i]), DATA_W'(exp_order[i]));
        chk("rr_writes", DATA_W'(obs_wr), DATA_W'(10));
        tick(); tick();

        // Requester c with len=0, then d must win next
        do_reset();
        clear_obs();
        req = 4'b0100; valid = 4'b0100; data[2] = hdr(0);
        run_until_done(20);
        chk("c_writes", DATA_W'(obs_wr), DATA_W'(1));
        chk("c_grant",  DATA_W'(done_q.size() > 0 ? done_q[0] : -1), DATA_W'(2));
        clear_obs();
        req = 4'b1111; valid = 4'b1111;
        for (int i = 0; i < 4; i++) data[i] = hdr(0);
        run_until_done(20);
        req = '0; valid = '0;
        chk("c_next_grant", DATA_W'(done_q.size() > 0 ? done_q[0] : -1), DATA_W'(3));
        tick();

        // len=4 with a three-cycle FIFO stall after the 2nd payload beat
        do_reset();
        clear_obs();
        req = 4'b0001; valid = 4'b0001; data[0] = hdr(4);
        stall = 3;
        n = 0;
        while (obs_done == 0 && n < 40) begin
            full = (obs_wr == 3 && stall > 0);
            if (full) stall--;
            tick();
            n++;
        end
        full = 1'b0; req = '0; valid = '0;
        chk("stall_writes",   DATA_W'(obs_wr),        DATA_W'(5));
        chk("stall_no_xfer",  DATA_W'(obs_stall_bad), DATA_W'(0));
        chk("stall_consumed", DATA_W'(stall),         DATA_W'(0));
        tick();

        // Non-granted b presents 0xDEAD during a's len=8 packet
        do_reset();
        clear_obs();
        req = 4'b0001; valid = 4'b0011; data[0] = hdr(8); data[1] = DATA_W'(16'hDEAD);
        run_until_done(40);
        req = '0; valid = '0;
        chk("dead_writes",  DATA_W'(obs_dead), DATA_W'(0));
        chk("dead_ready_b", DATA_W'(obs_rdyb), DATA_W'(0));
        chk("a8_writes",    DATA_W'(obs_wr),   DATA_W'(9));
        tick();

        // Reset in the middle of a len=10 packet after its 3rd payload beat
        do_reset();
        clear_obs();
        req = 4'b0001; valid = 4'b0001; data[0] = hdr(0);
        run_until_done(20);
        clear_obs();
        data[0] = hdr(10);
        n = 0;
        while (obs_wr < 4 && n < 30) begin tick(); n++; end
        chk("mid_writes", DATA_W'(obs_wr), DATA_W'(4));
        clear_obs();
        reset = 1'b1;
        tick();
        reset = 1'b0; req = 4'b1111; valid = 4'b0000;
        chk("abort_busy", DATA_W'(busy),     DATA_W'(0));
        chk("abort_resp", DATA_W'(resp),     DATA_W'(0));
        chk("abort_done", DATA_W'(pkt_done), DATA_W'(0));
        tick();
        chk("abort_grant", DATA_W'(grant_id), DATA_W'(0));
        chk("abort_resp2", DATA_W'(resp),     DATA_W'(4'b0001));
        tick(); tick();
        chk("abort_no_done", DATA_W'(obs_done), DATA_W'(0));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req   = 4'($urandom);
            valid = 4'($urandom | $urandom);
            full  = ($urandom % 5) == 0;
            for (int k = 0; k < 4; k++) data[k] = hdr(int'($urandom % 5));
            reset = ($urandom % 400) == 0;
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
